// File: rtl/instr_pkg.sv
// Shared definitions for the 12-bit instruction interface: field layout and sequencer states.
package instr_pkg;

  localparam int INSTR_W = 12;
  localparam int OP_W    = 3;
  localparam int REG_W   = 3;

  localparam int OP_LSB   = 9;
  localparam int SRC1_LSB = 6;
  localparam int SRC2_LSB = 3;
  localparam int DST_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/instr_rom.sv
// Program store: DEPTH x INSTR_W array with a synchronous write port and a combinational read port.
module instr_rom
  import instr_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      wa,
  input  logic [INSTR_W-1:0] wd,
  input  logic [AW-1:0]      ra,
  output logic [INSTR_W-1:0] rd
);

  // No reset on the array: program contents must survive a sequencer reset.
  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd = mem[ra];

endmodule

// File: rtl/instr_sequencer.sv
// Issues a stored program one instruction at a time over a valid/ready handshake.
// Optional macro SEQ_LOOP_EN adds a 'loop' input that restarts the program instead of finishing.
module instr_sequencer
  import instr_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               start,
  input  logic [AW:0]        prog_len,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
`ifdef SEQ_LOOP_EN
  input  logic               loop,
`endif
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               done
);

  localparam logic [AW-1:0] PC_ONE  = 1;
  localparam logic [AW:0]   LEN_ONE = 1;
  localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);

  state_t             state;
  logic [AW:0]        len;
  logic [AW-1:0]      rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic [AW:0]        len_clamped;
  logic               xfer;
  logic               last;
  logic               loop_en;

`ifdef SEQ_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign xfer        = instr_valid & instr_ready;
  assign last        = ({1'b0, pc} == (len - LEN_ONE));
  assign len_clamped = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;

  // The read port always looks one slot ahead so the next instruction can be registered on transfer.
  assign rd_addr = (state == RUN && !last) ? (pc + PC_ONE) : '0;

  instr_rom #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rom (
    .clk (clk),
    .we  (wr_en && (state == IDLE)),
    .wa  (wr_addr),
    .wd  (wr_data),
    .ra  (rd_addr),
    .rd  (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len         <= '0;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (prog_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              len         <= len_clamped;
              pc          <= '0;
              instr       <= rd_data;
              instr_valid <= 1'b1;
              busy        <= 1'b1;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            if (!last) begin
              pc    <= pc + PC_ONE;
              instr <= rd_data;
            end else if (loop_en) begin
              pc    <= '0;
              instr <= rd_data;
            end else begin
              instr_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus queues expected transfers, a monitor checks them.
module tb_instr_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct {
    logic [11:0]   instr;
    logic [AW-1:0] pc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [11:0]   wr_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic [11:0]   instr;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
`ifdef SEQ_LOOP_EN
  logic          loop = 1'b0;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  logic [11:0] tb_mem [DEPTH];

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .prog_len    (prog_len),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
`ifdef SEQ_LOOP_EN
    .loop        (loop),
`endif
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Monitor: every valid cycle is compared against the queue head; the head is popped on transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid) begin
        if (exp_q.size() == 0) begin
          if (instr_ready) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer: instr=%03h pc=%0d, required no transfer", instr, pc);
          end
        end else begin
          e = exp_q[0];
          checks++;
          if (instr !== e.instr || pc !== e.pc || busy !== 1'b1) begin
            errors++;
            $display("FAIL xfer: instr=%03h pc=%0d busy=%b, required instr=%03h pc=%0d busy=1",
                     instr, pc, busy, e.instr, e.pc);
          end else begin
            $display("xfer %s instr=%03h pc=%0d", instr_ready ? "take" : "hold", instr, pc);
          end
          if (instr_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check %s = %0h", name, act);
    end
  endtask

  task automatic write_slot(input int a, input logic [11:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    tb_mem[a] = d;
  endtask

  task automatic expect_slots(input int n, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < n; i++)
        exp_q.push_back('{instr: tb_mem[i], pc: AW'(i)});
  endtask

  // Returns one step after the edge that samples start.
  task automatic pulse_start(input int pl);
    @(posedge clk); #1;
    prog_len = (AW+1)'(pl); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // k counts negedges from the next one until done is seen.
  task automatic wait_done(input string name, input int exp_k);
    int k = 0;
    bit found = 0;
    while (!found && k < 200) begin
      @(negedge clk);
      if (done) found = 1;
      else k++;
    end
    check({name, "_done_time"}, found ? k : -1, exp_k);
    if (found) begin
      check({name, "_end_valid_busy"}, {instr_valid, busy}, 2'b00);
      @(negedge clk);
      check({name, "_done_one_cycle"}, done, 1'b0);
    end
    check({name, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {instr, instr_valid, pc, busy, done}, '0);
    rst = 1'b0;

    write_slot(0, 12'h0F8);
    write_slot(1, 12'h041);
    write_slot(2, 12'hA0A);
    write_slot(3, 12'hC0B);
    instr_ready = 1'b1;

    // Basic run: four back-to-back transfers, done right after the last.
    expect_slots(4, 1);
    pulse_start(4);
    wait_done("basic", 4);
    check("basic_pc_retained", pc, 3);

    // Backpressure: hold 041 for three cycles.
    expect_slots(4, 1);
    pulse_start(4);
    @(posedge clk); #1;
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_held_pc", pc, 1);
    instr_ready = 1'b1;
    wait_done("backpressure", 3);

    // Zero length: done with nothing issued.
    pulse_start(0);
    wait_done("len0", 0);

    // Write/start protection during RUN.
    expect_slots(4, 1);
    pulse_start(4);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 12'hFFF; start = 1'b1; prog_len = 5'd2;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    wait_done("protect", 3);

    // Full depth and oversize length.
    for (int i = 4; i < DEPTH; i++) write_slot(i, 12'(i * 12'h111));
    expect_slots(DEPTH, 1);
    pulse_start(DEPTH);
    wait_done("len16", DEPTH);
    check("len16_last_pc", pc, 15);
    expect_slots(DEPTH, 1);
    pulse_start(20);
    wait_done("len20_clamp", DEPTH);

    // Asynchronous reset at pc=2, then restart from retained memory.
    expect_slots(4, 1);
    pulse_start(4);
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_reset_pc", pc, 2);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {instr, instr_valid, pc, busy, done}, '0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    expect_slots(4, 1);
    pulse_start(4);
    wait_done("after_reset", 4);

`ifdef SEQ_LOOP_EN
    // Loop: wrap twice, then finish after the next 041.
    loop = 1'b1;
    expect_slots(2, 3);
    pulse_start(2);
    repeat (4) @(posedge clk);
    #1;
    loop = 1'b0;
    wait_done("loop", 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
